// File: rtl/baccarat_dealer.sv
// Baccarat dealer: deals player/dealer cards into hand registers, applies the
// third-card rules from external hand scores, and drives the win lights.
module baccarat_dealer #(
  parameter int unsigned DECK_MAX = 13,
  parameter int unsigned FACE_MIN = 10
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       step,
  input  logic       force_en,
  input  logic [3:0] force_card,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] deal_card,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
);

  localparam int unsigned CW = 4;

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_DEC, S_P3, S_BDEC, S_D3, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   dealt_c;
  logic [CW-1:0]   p3_eff;
  logic            banker_draw;
  logic            ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3;
  logic            clr;
  logic            pwin_d, dwin_d;

  assign dealt_c = force_en ? force_card : deal_card;

  // Banker third-card table; face cards count as zero.
  always_comb begin
    p3_eff      = (pcard3 >= CW'(FACE_MIN)) ? '0 : pcard3;
    banker_draw = 1'b0;
    if (dscore <= CW'(2))
      banker_draw = 1'b1;
    else if (dscore == CW'(3))
      banker_draw = (p3_eff != CW'(8));
    else if (dscore == CW'(4))
      banker_draw = (p3_eff >= CW'(2)) && (p3_eff <= CW'(7));
    else if (dscore == CW'(5))
      banker_draw = (p3_eff >= CW'(4)) && (p3_eff <= CW'(7));
    else if (dscore == CW'(6))
      banker_draw = (p3_eff >= CW'(6)) && (p3_eff <= CW'(7));
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state_q <= S_P1;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_p1   = 1'b0;
    ld_p2   = 1'b0;
    ld_p3   = 1'b0;
    ld_d1   = 1'b0;
    ld_d2   = 1'b0;
    ld_d3   = 1'b0;
    clr     = 1'b0;
    pwin_d  = 1'b0;
    dwin_d  = 1'b0;
    case (state_q)
      S_P1: if (step) begin ld_p1 = 1'b1; state_d = S_D1; end
      S_D1: if (step) begin ld_d1 = 1'b1; state_d = S_P2; end
      S_P2: if (step) begin ld_p2 = 1'b1; state_d = S_D2; end
      S_D2: if (step) begin ld_d2 = 1'b1; state_d = S_DEC; end
      S_DEC: begin
        if (step) begin
          if ((pscore >= CW'(8)) || (dscore >= CW'(8))) state_d = S_DONE;
          else if (pscore <= CW'(5))                    state_d = S_P3;
          else if (dscore <= CW'(5))                    state_d = S_D3;
          else                                          state_d = S_DONE;
        end
      end
      S_P3:   if (step) begin ld_p3 = 1'b1; state_d = S_BDEC; end
      S_BDEC: if (step) state_d = banker_draw ? S_D3 : S_DONE;
      S_D3:   if (step) begin ld_d3 = 1'b1; state_d = S_DONE; end
      S_DONE: begin
        if (step) begin
          clr     = 1'b1;
          state_d = S_P1;
        end else begin
          pwin_d = (pscore >= dscore);
          dwin_d = (dscore >= pscore);
        end
      end
      default: state_d = S_P1;
    endcase
  end

  // Free-running deck counter, 1..DECK_MAX.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)                         deal_card <= CW'(1);
    else if (deal_card == CW'(DECK_MAX)) deal_card <= CW'(1);
    else                                 deal_card <= deal_card + CW'(1);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1 <= '0;
      pcard2 <= '0;
      pcard3 <= '0;
      dcard1 <= '0;
      dcard2 <= '0;
      dcard3 <= '0;
    end else if (clr) begin
      pcard1 <= '0;
      pcard2 <= '0;
      pcard3 <= '0;
      dcard1 <= '0;
      dcard2 <= '0;
      dcard3 <= '0;
    end else begin
      if (ld_p1) pcard1 <= dealt_c;
      if (ld_p2) pcard2 <= dealt_c;
      if (ld_p3) pcard3 <= dealt_c;
      if (ld_d1) dcard1 <= dealt_c;
      if (ld_d2) dcard2 <= dealt_c;
      if (ld_d3) dcard3 <= dealt_c;
    end
  end

  // done follows the next state so it rises on the entry edge.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      done             <= 1'b0;
    end else begin
      player_win_light <= pwin_d;
      dealer_win_light <= dwin_d;
      done             <= (state_d == S_DONE);
    end
  end

endmodule
